// File: rtl/exe_mem_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mem_reg_pkg
//  Purpose  : Shared definitions for the EXE/MEM pipeline register: default
//             datapath widths, {N,Z,C,V} flag bit positions and the 4-bit
//             execute-command encodings used by the ALU.
//  Revision : 1.0  initial release
// ============================================================================
package exe_mem_reg_pkg;

    localparam int c_DATA_W_DEFAULT = 32;
    localparam int c_REG_W_DEFAULT  = 4;

    // Bit positions of the flags inside the 4-bit status word {N,Z,C,V}
    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_MVN = 4'b1001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000
    } exe_cmd_e;

endpackage : exe_mem_reg_pkg
`default_nettype wire

// File: rtl/exe_mem_reg_status_reg.sv
`default_nettype none
// ============================================================================
//  Module   : status_reg
//  Purpose  : Architectural {N,Z,C,V} flag register with load enable and
//             asynchronous active-high reset. Also exports the carry flag
//             for the ALU carry-in.
//  Ports    : clk, rst      - clock, async active-high reset
//             i_load        - capture i_flags on this rising edge
//             i_flags[3:0]  - new {N,Z,C,V}
//             o_status[3:0] - current {N,Z,C,V}
//             o_cin         - current C flag
//  Revision : 1.0  initial release
// ============================================================================
module status_reg
    import exe_mem_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_flags,
    output logic [3:0] o_status,
    output logic       o_cin
);

    logic [3:0] r_status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= 4'b0000;
        end else if (i_load) begin
            r_status <= i_flags;
        end
    end

    assign o_status = r_status;
    // Carry comes from the registered flags, so an instruction sees the
    // carry produced by the instruction before it.
    assign o_cin    = r_status[c_FLAG_C];

endmodule : status_reg
`default_nettype wire

// File: rtl/exe_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mem_reg
//  Purpose  : EXE -> MEM pipeline register with stall (freeze), squash
//             (flush), flag register and retired-instruction counter.
//  Ports    : clk, rst                         - clock, async active-high reset
//             freeze, flush, in_valid          - pipeline control
//             wb_en_in, mem_r_en_in, mem_w_en_in, s_en_in - EXE control bits
//             alu_result_in, alu_status_in, st_val_in, dest_in - EXE data
//             out_valid, wb_en, mem_r_en, mem_w_en - registered controls
//             alu_result, st_val, dest         - registered data
//             status, cin                      - flag register, carry feedback
//             retired                          - saturating accept counter
//  Revision : 1.0  initial release
// ============================================================================
module exe_mem_reg
    import exe_mem_reg_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int REG_W  = c_REG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              s_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [3:0]        alu_status_in,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [REG_W-1:0]  dest_in,
    output logic              out_valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_val,
    output logic [REG_W-1:0]  dest,
    output logic [3:0]        status,
    output logic              cin,
    output logic [31:0]       retired
);

    logic              w_accept;
    logic              r_valid;
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic              r_mem_w_en;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_st_val;
    logic [REG_W-1:0]  r_dest;
    logic [31:0]       r_retired;

    // freeze outranks flush, which outranks in_valid
    assign w_accept = ~freeze & ~flush & in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_wb_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_mem_w_en   <= 1'b0;
            r_alu_result <= '0;
            r_st_val     <= '0;
            r_dest       <= '0;
        end else if (!freeze) begin
            if (w_accept) begin
                r_valid      <= 1'b1;
                r_wb_en      <= wb_en_in;
                r_mem_r_en   <= mem_r_en_in;
                r_mem_w_en   <= mem_w_en_in;
                r_alu_result <= alu_result_in;
                r_st_val     <= st_val_in;
                r_dest       <= dest_in;
            end else begin
                // Bubble: kill the controls only; the data is don't-care
                // downstream and is left in place.
                r_valid    <= 1'b0;
                r_wb_en    <= 1'b0;
                r_mem_r_en <= 1'b0;
                r_mem_w_en <= 1'b0;
            end
        end
    end

    // Saturating counter: sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= 32'd0;
        end else if (w_accept && (r_retired != 32'hFFFF_FFFF)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    status_reg u_status_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept & s_en_in),
        .i_flags  (alu_status_in),
        .o_status (status),
        .o_cin    (cin)
    );

    assign out_valid  = r_valid;
    assign wb_en      = r_wb_en;
    assign mem_r_en   = r_mem_r_en;
    assign mem_w_en   = r_mem_w_en;
    assign alu_result = r_alu_result;
    assign st_val     = r_st_val;
    assign dest       = r_dest;
    assign retired    = r_retired;

endmodule : exe_mem_reg
`default_nettype wire
